// File: rtl/y86_pkg.sv
// Shared Y86 constants and the writeback sequencer state type.
// Used by regfile_wb_sequencer and its bench.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } wb_state_t;

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Writeback packet channel from the memory stage into regfile_wb_sequencer.
//
// Handshake: the packet (icode, cnd, dstE, dstM, valE, valM) transfers on the
// rising edge where wb_valid && wb_ready are both high. While wb_valid is high
// and the transfer has not happened, the master holds the packet unchanged.
interface regfile_wb_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        icode;
    logic              cnd;
    logic [ADDR_W-1:0] dstE;
    logic [ADDR_W-1:0] dstM;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;

    modport master (
        output wb_valid, icode, cnd, dstE, dstM, valE, valM,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, icode, cnd, dstE, dstM, valE, valM,
        output wb_ready
    );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Serialises Y86 writeback packets onto the single register-file write port
// and tracks pending writes. Optional: REGFILE_WB_BACK2BACK_EN (accept in last write state).
module regfile_wb_sequencer
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_sequencer_if.slave wb,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  busy,
    output wb_state_t             dbg_state
);

    localparam logic [ADDR_W-1:0] REG_NONE = ADDR_W'(RNONE);

    wb_state_t         state;
    logic [ADDR_W-1:0] lat_e;
    logic [ADDR_W-1:0] lat_m;
    logic [DATA_W-1:0] lat_vm;

    logic [ADDR_W-1:0] eff_e;
    logic              accept;
    wb_state_t         first_state;
    logic [ADDR_W-1:0] first_addr;
    logic [DATA_W-1:0] first_data;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // One-hot of a register index; RNONE (and anything >= NUM_REGS) maps to zero.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m[i] = (idx == ADDR_W'(i));
        end
        return m;
    endfunction

    always_comb begin
        eff_e = ((wb.icode == IRRMOVQ) && !wb.cnd) ? REG_NONE : wb.dstE;

`ifdef REGFILE_WB_BACK2BACK_EN
        wb.wb_ready = (state == IDLE) || (state == WR_M) ||
                      ((state == WR_E) && (lat_m == REG_NONE));
`else
        wb.wb_ready = (state == IDLE);
`endif

        accept = wb.wb_valid && wb.wb_ready;

        first_state = IDLE;
        first_addr  = REG_NONE;
        first_data  = '0;
        if (eff_e != REG_NONE) begin
            first_state = WR_E;
            first_addr  = eff_e;
            first_data  = wb.valE;
        end else if (wb.dstM != REG_NONE) begin
            first_state = WR_M;
            first_addr  = wb.dstM;
            first_data  = wb.valM;
        end

        set_mask = accept ? (reg_bit(eff_e) | reg_bit(wb.dstM)) : '0;

        // A shared E/M destination keeps its bit until the M write completes.
        clr_mask = '0;
        case (state)
            WR_E:    clr_mask = (lat_e != lat_m) ? reg_bit(lat_e) : '0;
            WR_M:    clr_mask = reg_bit(lat_m);
            default: clr_mask = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= REG_NONE;
            rf_wdata <= '0;
            pending  <= '0;
            lat_e    <= REG_NONE;
            lat_m    <= REG_NONE;
            lat_vm   <= '0;
        end else begin
            // Set wins over clear when a new packet targets the register being written.
            pending <= (pending & ~clr_mask) | set_mask;
            if (accept) begin
                lat_e    <= eff_e;
                lat_m    <= wb.dstM;
                lat_vm   <= wb.valM;
                state    <= first_state;
                rf_we    <= (first_state != IDLE);
                rf_waddr <= first_addr;
                rf_wdata <= first_data;
            end else if ((state == WR_E) && (lat_m != REG_NONE)) begin
                state    <= WR_M;
                rf_we    <= 1'b1;
                rf_waddr <= lat_m;
                rf_wdata <= lat_vm;
            end else begin
                state    <= IDLE;
                rf_we    <= 1'b0;
                rf_waddr <= REG_NONE;
                rf_wdata <= '0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    a_no_rnone_write: assert property (@(posedge clk) disable iff (!rst_n)
        rf_we |-> (rf_waddr != REG_NONE));
    a_we_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        rf_we == (state != IDLE));

endmodule

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Owns the single write port of the Y86 15-entry register file (R0–R14).
- Accepts one writeback packet per instruction: dstE/valE and dstM/valM. Dual-destination instructions (popq) are serialised over two cycles, E write first, then M write.
- Keeps a pending-write scoreboard so decode can stall on registers not yet written.
- Sits between the memory stage and the register file, alongside decode's read ports.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 4, register index width
- NUM_REGS, 15, architectural registers (index 15 = RNONE)
- RNONE, 4'hF, "no register" encoding; never written

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  writeback packet offered
- wb_ready  output  1  sequencer can accept packet this cycle
- icode  input  4  instruction code of packet
- cnd  input  1  condition result (cmovXX gating)
- dstE  input  ADDR_W  destination for valE
- dstM  input  ADDR_W  destination for valM
- valE  input  DATA_W  ALU result
- valM  input  DATA_W  memory read data
- rf_we  output  1  register-file write enable
- rf_waddr  output  ADDR_W  register-file write index
- rf_wdata  output  DATA_W  register-file write data
- pending  output  NUM_REGS  bit i = write to Ri accepted but not yet performed
- busy  output  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; rf_we=0, rf_waddr=RNONE, rf_wdata=0, pending=0, busy=0; latched packet cleared. Reset mid-sequence discards any unwritten M write.
- Handshake: a packet transfers on the rising edge where wb_valid && wb_ready. wb_ready = (state==IDLE). wb_valid held without ready must not change the packet.
- E gating: effE = dstE, except when icode==2 (rrmovq/cmovXX) and cnd==0, then effE = RNONE.
- States:
  - IDLE: on accept, latch effE, dstM, valE, valM. Next state WR_E if effE!=RNONE, else WR_M if dstM!=RNONE, else IDLE (nothing written).
  - WR_E: rf_we=1, rf_waddr=effE, rf_wdata=valE for exactly one cycle. Next state WR_M if dstM!=RNONE, else IDLE.
  - WR_M: rf_we=1, rf_waddr=dstM, rf_wdata=valM for one cycle. Next state IDLE.
- Outputs rf_* are registered. The first write is visible in the cycle after accept, so latency is 1 cycle to the E write and 2 cycles to the M write for dual writes.
- Same destination (popq %rsp: effE==dstM==4): both writes performed, M last, so R4 ends holding valM (Y86 semantics).
- Scoreboard:
  - On accept, set pending bits for effE and dstM (RNONE ignored).
  - Clear each bit in the cycle its write is driven (register update visible the next edge).
  - When effE==dstM, the bit stays set until the M write.
- busy = (state != IDLE).
- rf_we is never asserted with rf_waddr==RNONE.
- Index range: dst values 0–14 are valid.

Optional Feature:
- Macro: REGFILE_WB_BACK2BACK_EN.
- Enabled:
  - wb_ready is also high in the last write state of a sequence (WR_M, or WR_E when no M write follows).
  - A new packet accepted there goes directly to its first write state the next cycle, giving one write per cycle sustained throughput.
  - Pending bits: set for the new packet, cleared for the current write, in the same cycle; set wins if the indices match.
- Disabled: wb_ready only in IDLE, giving one idle cycle between packets.

Decomposition:
- Shared package y86_pkg holds:
  - Icode constants (IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11).
  - Register constants RRSP=4, RNONE=15.
  - The wb state enum {IDLE, WR_E, WR_M}.
- No sub-module is needed; the scoreboard is a small in-module register vector.

Test Plan:
- Reset mid-WR_E: packet popq (dstE=4, dstM=3) accepted, rst_n low during WR_E → all outputs at reset values immediately; no write to R3; pending=0.
- OPq: icode=6, dstE=2, valE=0x1234, dstM=F → one write R2=0x1234 one cycle after accept; pending[2] high for one cycle; back to IDLE.
- cmov not taken: icode=2, cnd=0, dstE=5 → no rf_we; pending stays 0.
- cmov taken: icode=2, cnd=1, dstE=5, valE=7 → R5=7 written.
- popq %rbx: dstE=4, valE=0x108, dstM=3, valM=0xAB → R4=0x108 then R3=0xAB on consecutive cycles; wb_ready low for 2 cycles.
- popq %rsp: dstE=dstM=4, valE=0x108, valM=0x55 → writes 0x108 then 0x55; pending[4] clears only after the second write; R4 final value 0x55.
- Back-to-back (macro on): two OPq packets offered continuously → writes on consecutive cycles with no bubble. With macro off → a one-cycle gap between the writes.
